// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
// ALU codes track the control_unit alu_control encoding.
package muldiv_pkg;

  localparam logic [2:0] ALU_MUL  = 3'b010;
  localparam logic [2:0] ALU_DIV  = 3'b011;
  localparam logic [2:0] ALU_REMU = 3'b100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    MUL  = ST_MUL,
    DIV  = ST_DIV,
    DONE = ST_DONE
  } state_t;

  function automatic logic is_muldiv_op(input logic [2:0] code);
    return (code == ALU_MUL) || (code == ALU_DIV) || (code == ALU_REMU);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One restoring-division step: shift in a dividend bit, then subtract the
// divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem, dvd_bit};
  assign diff    = shifted - {1'b0, divisor};

  // shifted < 2*divisor, so a non-negative difference always fits in WIDTH bits
  // and the borrow bit alone decides the quotient bit.
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiplier / restoring divider for the execute stage,
// with the FSM that stalls the pipeline while it iterates.
//
// state | meaning
// IDLE  | waiting for a MUL/DIV/REMU from execute
// MUL   | one shift-add step per clock
// DIV   | one restoring-divide step per clock
// DONE  | result valid for one cycle, pipeline released
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             dbz;

  logic             valid_op;
  logic             last_step;
  logic [WIDTH-1:0] mul_acc_next;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] quo_next;

  assign valid_op  = start && is_muldiv_op(op);
  assign last_step = (cnt == CNT_ONE);

  // a_reg is the multiplicand in MUL; in DIV it holds the dividend and the
  // quotient bits shift in behind it, so it ends up as the quotient.
  assign mul_acc_next = acc + (b_reg[0] ? a_reg : '0);
  assign quo_next     = {a_reg[WIDTH-2:0], q_bit};

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem      (acc),
    .dvd_bit  (a_reg[WIDTH-1]),
    .divisor  (b_reg),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_reg <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      cnt    <= '0;
      dbz    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_op && !flush) begin
            op_reg <= op;
            a_reg  <= src_a;
            b_reg  <= src_b;
            acc    <= '0;
            cnt    <= CNT_LOAD;
            dbz    <= 1'b0;
            if (op == ALU_MUL) begin
              state <= MUL;
            end else if (src_b == '0) begin
              state  <= DONE;
              dbz    <= 1'b1;
              result <= (op == ALU_REMU) ? src_a : '1;
            end else begin
              state <= DIV;
            end
          end
        end
        MUL: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc   <= mul_acc_next;
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
            cnt   <= cnt - CNT_ONE;
            if (last_step) begin
              state  <= DONE;
              result <= mul_acc_next;
            end
          end
        end
        DIV: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc   <= rem_next;
            a_reg <= quo_next;
            cnt   <= cnt - CNT_ONE;
            if (last_step) begin
              state  <= DONE;
              result <= (op_reg == ALU_REMU) ? rem_next : quo_next;
            end
          end
        end
        DONE: begin
          // The retiring instruction is still presented, so start is ignored.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall       = ((state == IDLE) && valid_op && !flush) || (state == MUL) || (state == DIV);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign div_by_zero = done && dbz;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops push expected results,
// a negedge monitor pops and compares whenever done is seen.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         flush = 1'b0;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         div_by_zero;

  int n_vec  = 0;
  int n_fail = 0;

  logic [W:0]   sb_q[$];
  logic [W:0]   mon_exp;
  logic [W-1:0] last_res = '0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_done: got done with result %h, expected no done", result);
      end else begin
        mon_exp = sb_q.pop_front();
        check("result", result, mon_exp[W-1:0]);
        check("div_by_zero", W'(div_by_zero), W'(mon_exp[W]));
      end
    end
  end

  // Waits for done from cycle 0; checks latency, stall while iterating, and stall low at done.
  task automatic wait_done(input string name, input int lat);
    int cyc = 0;
    logic stall_ok = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (done !== 1'b1 && stall !== 1'b1) stall_ok = 1'b0;
    end while (done !== 1'b1 && cyc < 80);
    check({name, "_latency"}, W'(cyc), W'(lat));
    check({name, "_stall_iter"}, W'(stall_ok), W'(1));
    check({name, "_stall_done"}, W'(stall), W'(0));
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic edbz,
                        input int lat, input logic b2b);
    if (!b2b) @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    sb_q.push_back({edbz, er});
    last_res = er;
    if (b2b) @(negedge clk);
    #1;
    check({name, "_stall_c0"}, W'(stall), W'(1));
    check({name, "_busy_c0"}, W'(busy), W'(0));
    wait_done(name, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_stall", W'(stall), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_result", result, W'(0));
    check("rst_dbz", W'(div_by_zero), W'(0));
    rst_n = 1'b1;

    run_op("mul_7x6", ALU_MUL, 32'd7, 32'd6, 32'd42, 1'b0, 33, 1'b0);
    @(negedge clk);
    check("mul_7x6_busy_c34", W'(busy), W'(0));

    run_op("div_100_7", ALU_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 33, 1'b0);
    run_op("remu_100_7", ALU_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 33, 1'b0);
    run_op("div_5_0", ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1, 1'b0);
    run_op("remu_5_0", ALU_REMU, 32'd5, 32'd0, 32'd5, 1'b1, 1, 1'b0);
    run_op("mul_wrap0", ALU_MUL, 32'h8000_0000, 32'd2, 32'd0, 1'b0, 33, 1'b0);
    run_op("mul_ffff_sq", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 33, 1'b0);
    run_op("div_max_1", ALU_DIV, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 33, 1'b0);
    run_op("remu_max_16", ALU_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 1'b0, 33, 1'b0);
    run_op("div_3_7", ALU_DIV, 32'd3, 32'd7, 32'd0, 1'b0, 33, 1'b0);
    run_op("remu_big", ALU_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, 1'b0);

    // Flush at cycle 10 of a DIV: no done, result untouched.
    @(negedge clk);
    start = 1'b1; op = ALU_DIV; src_a = 32'd100; src_b = 32'd7;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("flush_div_busy", W'(busy), W'(0));
    check("flush_div_stall", W'(stall), W'(0));
    flush = 1'b0;
    repeat (40) @(negedge clk);
    check("flush_div_result_held", result, last_res);

    // Flush in IDLE blocks acceptance of a valid op.
    start = 1'b1; op = ALU_MUL; src_a = 32'd3; src_b = 32'd3; flush = 1'b1;
    #1;
    check("flush_idle_stall", W'(stall), W'(0));
    @(negedge clk);
    check("flush_idle_busy", W'(busy), W'(0));
    start = 1'b0; flush = 1'b0;

    // Illegal op is ignored.
    start = 1'b1; op = 3'b000; src_a = 32'd3; src_b = 32'd3;
    #1;
    check("illegal_stall", W'(stall), W'(0));
    repeat (3) @(negedge clk);
    check("illegal_busy", W'(busy), W'(0));
    start = 1'b0;

    // Reset at cycle 15 of a MUL discards the partial result.
    @(negedge clk);
    start = 1'b1; op = ALU_MUL; src_a = 32'd3; src_b = 32'd5;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("midrst_stall", W'(stall), W'(0));
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_done", W'(done), W'(0));
    check("midrst_result", result, W'(0));
    check("midrst_dbz", W'(div_by_zero), W'(0));
    rst_n = 1'b1;

    // Back-to-back: second op presented during DONE, accepted in the following IDLE cycle.
    run_op("b2b_mul", ALU_MUL, 32'd9, 32'd9, 32'd81, 1'b0, 33, 1'b0);
    run_op("b2b_div", ALU_DIV, 32'd1000, 32'd10, 32'd100, 1'b0, 33, 1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", W'(sb_q.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
